// File: rtl/id_ex_operand_stage_pkg.sv
// Shared encodings for the EX stage: ALU control codes, aluop classes, R-type funct values.
// The ALU decodes the same alu_ctrl_e values.
package id_ex_operand_stage_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int REG_AW_DEF = 5;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_INV   = 2'b11
    } aluop_e;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_INV = 3'b011,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

endpackage

// File: rtl/id_ex_operand_stage_alu_control.sv
// Combinational aluop/funct decode into the 3-bit ALU control code.
module id_ex_operand_stage_alu_control
    import id_ex_operand_stage_pkg::*;
(
    input  logic [1:0] i_aluop,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_INV;
        case (i_aluop)
            ALUOP_ADD: o_alu_control = ALU_ADD;
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_control = ALU_ADD;
                    FUNCT_SUB: o_alu_control = ALU_SUB;
                    FUNCT_AND: o_alu_control = ALU_AND;
                    FUNCT_OR:  o_alu_control = ALU_OR;
                    FUNCT_SLT: o_alu_control = ALU_SLT;
                    default:   o_alu_control = ALU_INV;
                endcase
            end
            default: o_alu_control = ALU_INV;
        endcase
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side forwarding muxes, load-use hazard detection
// and ALU control decode.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [1:0]        id_aluop,
    input  logic [5:0]        id_funct,
    input  logic              id_alusrc,
    input  logic              id_regdst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              id_memtoreg,
    input  logic              id_branch,
    input  logic              flush,
    input  logic              exmem_regwrite,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic [DATA_W-1:0] exmem_result,
    input  logic              memwb_regwrite,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic [DATA_W-1:0] memwb_result,
    output logic              stall,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_control,
    output logic              ex_valid,
    output logic [REG_AW-1:0] ex_dest,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic              ex_memwrite,
    output logic              ex_memtoreg,
    output logic              ex_branch,
    output logic [DATA_W-1:0] ex_imm
);

    logic              r_valid;
    logic [REG_AW-1:0] r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_rdata1, r_rdata2, r_imm;
    logic [1:0]        r_aluop;
    logic [5:0]        r_funct;
    logic              r_alusrc, r_regdst, r_regwrite, r_memread;
    logic              r_memwrite, r_memtoreg, r_branch;

    logic              w_stall;
    logic              w_bubble;
    logic [DATA_W-1:0] w_fwd_a, w_fwd_b;

    // Gated by rst so a pending stall releases in the cycle reset is sampled.
    assign w_stall = !rst && id_valid && r_valid && r_memread && (r_rt != '0)
                     && ((r_rt == id_rs) || (r_rt == id_rt));
    assign w_bubble = flush || w_stall || !id_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_rs       <= '0;
            r_rt       <= '0;
            r_rd       <= '0;
            r_rdata1   <= '0;
            r_rdata2   <= '0;
            r_imm      <= '0;
            r_aluop    <= '0;
            r_funct    <= '0;
            r_alusrc   <= 1'b0;
            r_regdst   <= 1'b0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_branch   <= 1'b0;
        end else begin
            // Data fields are don't-care in a bubble, so they always follow ID.
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_rdata1 <= id_rdata1;
            r_rdata2 <= id_rdata2;
            r_imm    <= id_imm;
            r_funct  <= id_funct;
            if (w_bubble) begin
                r_valid    <= 1'b0;
                r_aluop    <= ALUOP_ADD;
                r_alusrc   <= 1'b0;
                r_regdst   <= 1'b0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_memwrite <= 1'b0;
                r_memtoreg <= 1'b0;
                r_branch   <= 1'b0;
            end else begin
                r_valid    <= 1'b1;
                r_aluop    <= id_aluop;
                r_alusrc   <= id_alusrc;
                r_regdst   <= id_regdst;
                r_regwrite <= id_regwrite;
                r_memread  <= id_memread;
                r_memwrite <= id_memwrite;
                r_memtoreg <= id_memtoreg;
                r_branch   <= id_branch;
            end
        end
    end

    // EX/MEM has priority over MEM/WB; register 0 is never forwarded.
    always_comb begin
        w_fwd_a = r_rdata1;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rs))
            w_fwd_a = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rs))
            w_fwd_a = memwb_result;
    end

    always_comb begin
        w_fwd_b = r_rdata2;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == r_rt))
            w_fwd_b = exmem_result;
        else if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == r_rt))
            w_fwd_b = memwb_result;
    end

    id_ex_operand_stage_alu_control u_alu_control (
        .i_aluop       (r_aluop),
        .i_funct       (r_funct),
        .o_alu_control (alu_control)
    );

    assign stall         = w_stall;
    assign alu_a         = w_fwd_a;
    assign alu_b         = r_alusrc ? r_imm : w_fwd_b;
    assign ex_store_data = w_fwd_b;
    assign ex_valid      = r_valid;
    assign ex_dest       = r_regdst ? r_rd : r_rt;
    assign ex_regwrite   = r_regwrite;
    assign ex_memread    = r_memread;
    assign ex_memwrite   = r_memwrite;
    assign ex_memtoreg   = r_memtoreg;
    assign ex_branch     = r_branch;
    assign ex_imm        = r_imm;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: decode table, directed pipeline
// corner cases and a randomized run against a behavioural model.
module tb_id_ex_operand_stage;

    typedef struct {
        logic [4:0]  rs, rt, rd;
        logic [31:0] rd1, rd2, imm;
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc, regdst, regwrite, memread, memwrite, memtoreg, branch;
    } instr_t;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic        alusrc;
        logic [31:0] imm;
        logic [2:0]  exp_ctrl;
    } dec_vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [1:0]  id_aluop;
    logic [5:0]  id_funct;
    logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch;
    logic        flush;
    logic        exmem_regwrite;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_regwrite;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        stall;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_control;
    logic        ex_valid;
    logic [4:0]  ex_dest;
    logic [31:0] ex_store_data;
    logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch;
    logic [31:0] ex_imm;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] fn_pool [7];
    dec_vec_t   dec_tab [8];

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .id_branch(id_branch), .flush(flush),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
        .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_imm(ex_imm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input instr_t x, input logic v);
        id_valid    = v;
        id_rs       = x.rs;
        id_rt       = x.rt;
        id_rd       = x.rd;
        id_rdata1   = x.rd1;
        id_rdata2   = x.rd2;
        id_imm      = x.imm;
        id_aluop    = x.aluop;
        id_funct    = x.funct;
        id_alusrc   = x.alusrc;
        id_regdst   = x.regdst;
        id_regwrite = x.regwrite;
        id_memread  = x.memread;
        id_memwrite = x.memwrite;
        id_memtoreg = x.memtoreg;
        id_branch   = x.branch;
    endtask

    task automatic clear_fwd();
        exmem_regwrite = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_regwrite = 1'b0; memwb_rd = '0; memwb_result = '0;
    endtask

    function automatic instr_t blank();
        instr_t x;
        x.rs = '0; x.rt = '0; x.rd = '0;
        x.rd1 = '0; x.rd2 = '0; x.imm = '0;
        x.aluop = 2'b00; x.funct = '0;
        x.alusrc = 0; x.regdst = 0; x.regwrite = 0; x.memread = 0;
        x.memwrite = 0; x.memtoreg = 0; x.branch = 0;
        return x;
    endfunction

    // Reference ALU control: straight lookup of the opcode table.
    function automatic logic [2:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
        logic [5:0] fn   [5];
        logic [2:0] code [5];
        fn[0] = 6'h20; code[0] = 3'b010;
        fn[1] = 6'h22; code[1] = 3'b110;
        fn[2] = 6'h24; code[2] = 3'b000;
        fn[3] = 6'h25; code[3] = 3'b001;
        fn[4] = 6'h2A; code[4] = 3'b111;
        if (op == 2'b00) return 3'b010;
        if (op == 2'b01) return 3'b110;
        if (op == 2'b11) return 3'b011;
        for (int i = 0; i < 5; i++)
            if (fn[i] == f) return code[i];
        return 3'b011;
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] src, input logic [31:0] rf);
        if (exmem_regwrite && exmem_rd != 0 && exmem_rd == src) return exmem_result;
        if (memwb_regwrite && memwb_rd != 0 && memwb_rd == src) return memwb_result;
        return rf;
    endfunction

    function automatic instr_t rand_instr();
        instr_t x;
        x.rs = 5'($urandom_range(0, 3)); x.rt = 5'($urandom_range(0, 3));
        x.rd = 5'($urandom_range(0, 31));
        x.rd1 = $urandom; x.rd2 = $urandom; x.imm = $urandom;
        x.aluop = 2'($urandom_range(0, 3));
        x.funct = fn_pool[$urandom_range(0, 6)];
        x.alusrc = 1'($urandom); x.regdst = 1'($urandom); x.regwrite = 1'($urandom);
        x.memread = ($urandom_range(0, 2) == 0); x.memwrite = 1'($urandom);
        x.memtoreg = 1'($urandom); x.branch = 1'($urandom);
        return x;
    endfunction

    instr_t m_slot;
    logic   m_valid;
    logic   exp_stall;
    instr_t x;

    initial begin
        fn_pool[0] = 6'h20; fn_pool[1] = 6'h22; fn_pool[2] = 6'h24; fn_pool[3] = 6'h25;
        fn_pool[4] = 6'h2A; fn_pool[5] = 6'h3F; fn_pool[6] = 6'h00;

        dec_tab[0] = '{2'b10, 6'h20, 1'b0, 32'h0, 3'b010};
        dec_tab[1] = '{2'b10, 6'h22, 1'b0, 32'h0, 3'b110};
        dec_tab[2] = '{2'b10, 6'h24, 1'b0, 32'h0, 3'b000};
        dec_tab[3] = '{2'b10, 6'h25, 1'b0, 32'h0, 3'b001};
        dec_tab[4] = '{2'b10, 6'h2A, 1'b0, 32'h0, 3'b111};
        dec_tab[5] = '{2'b10, 6'h3F, 1'b0, 32'h0, 3'b011};
        dec_tab[6] = '{2'b01, 6'h00, 1'b0, 32'h0, 3'b110};
        dec_tab[7] = '{2'b00, 6'h00, 1'b1, 32'hFFFF_FFFC, 3'b010};

        // Reset held 2 cycles with a live instruction in ID
        rst = 1'b1; flush = 1'b0; clear_fwd();
        x = blank(); x.regwrite = 1; x.aluop = 2'b10; x.funct = 6'h22;
        set_id(x, 1'b1);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_alu_control", 32'(alu_control), 32'b010);
        chk("reset_ex_regwrite", 32'(ex_regwrite), 32'd0);

        // Decode table
        for (int i = 0; i < 8; i++) begin
            x = blank();
            x.aluop = dec_tab[i].aluop; x.funct = dec_tab[i].funct;
            x.alusrc = dec_tab[i].alusrc; x.imm = dec_tab[i].imm; x.rd2 = 32'h1234_5678;
            set_id(x, 1'b1);
            tick();
            chk($sformatf("decode_%0d", i), 32'(alu_control), 32'(dec_tab[i].exp_ctrl));
            chk($sformatf("alu_b_%0d", i), alu_b,
                dec_tab[i].alusrc ? dec_tab[i].imm : 32'h1234_5678);
        end

        // Forward priority
        x = blank(); x.rs = 3; x.rd1 = 32'h99; x.regwrite = 1;
        set_id(x, 1'b1);
        tick();
        id_valid = 1'b0;
        exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'h11;
        memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'h22;
        #1 chk("fwd_exmem_wins", alu_a, 32'h11);
        exmem_regwrite = 0;
        #1 chk("fwd_memwb", alu_a, 32'h22);
        memwb_regwrite = 0;
        #1 chk("fwd_none", alu_a, 32'h99);

        // Register 0 never forwarded
        clear_fwd();
        x = blank(); x.rs = 0; x.rt = 0; x.rd1 = 0; x.rd2 = 0;
        set_id(x, 1'b1);
        tick();
        exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF_FFFF;
        memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'hFFFF_FFFF;
        #1 chk("reg0_alu_a", alu_a, 32'h0);
        chk("reg0_store", ex_store_data, 32'h0);
        clear_fwd();

        // Load-use: lw rt=5, then add rs=5
        x = blank(); x.rt = 5; x.memread = 1; x.regwrite = 1; x.memtoreg = 1; x.alusrc = 1;
        set_id(x, 1'b1);
        tick();
        x = blank(); x.rs = 5; x.rt = 6; x.rd = 7; x.aluop = 2'b10; x.funct = 6'h20;
        x.regdst = 1; x.regwrite = 1; x.rd1 = 32'hDEAD; x.rd2 = 32'h6;
        set_id(x, 1'b1);
        #1 chk("loaduse_stall", 32'(stall), 32'd1);
        tick();
        chk("loaduse_bubble", 32'(ex_valid), 32'd0);
        chk("loaduse_stall_drop", 32'(stall), 32'd0);
        tick();
        memwb_regwrite = 1; memwb_rd = 5; memwb_result = 32'hABCD;
        #1 chk("loaduse_add_valid", 32'(ex_valid), 32'd1);
        chk("loaduse_fwd", alu_a, 32'hABCD);
        chk("loaduse_dest", 32'(ex_dest), 32'd7);
        clear_fwd();

        // Flush during a load-use stall
        x = blank(); x.rt = 7; x.memread = 1; x.regwrite = 1;
        set_id(x, 1'b1);
        tick();
        x = blank(); x.rs = 7; x.regwrite = 1;
        set_id(x, 1'b1);
        flush = 1'b1;
        #1 chk("flush_stall_high", 32'(stall), 32'd1);
        tick();
        flush = 1'b0;
        chk("flush_ex_valid", 32'(ex_valid), 32'd0);
        chk("flush_ex_regwrite", 32'(ex_regwrite), 32'd0);

        // Reset while a stall is pending
        x = blank(); x.rt = 4; x.memread = 1;
        set_id(x, 1'b1);
        tick();
        x = blank(); x.rs = 4; x.regwrite = 1;
        set_id(x, 1'b1);
        #1 chk("rst_mid_stall_pre", 32'(stall), 32'd1);
        rst = 1'b1;
        #1 chk("rst_mid_stall_drop", 32'(stall), 32'd0);
        tick();
        rst = 1'b0;
        id_valid = 1'b0;
        #1 chk("rst_mid_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_mid_memread", 32'(ex_memread), 32'd0);

        // Randomized run against the model; slot is empty after the reset above
        m_slot = blank(); m_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            x = rand_instr();
            set_id(x, ($urandom_range(0, 4) != 0));
            flush = ($urandom_range(0, 9) == 0);
            exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            #1;
            exp_stall = id_valid && m_valid && m_slot.memread && m_slot.rt != 0
                        && (m_slot.rt == id_rs || m_slot.rt == id_rt);
            chk("rnd_stall", 32'(stall), 32'(exp_stall));
            chk("rnd_valid", 32'(ex_valid), 32'(m_valid));
            chk("rnd_ctrl", 32'(alu_control), 32'(m_valid ? ref_ctrl(m_slot.aluop, m_slot.funct) : 3'b010));
            chk("rnd_ctl_bits", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch}),
                m_valid ? 32'({m_slot.regwrite, m_slot.memread, m_slot.memwrite, m_slot.memtoreg, m_slot.branch}) : 32'd0);
            if (m_valid) begin
                chk("rnd_alu_a", alu_a, ref_fwd(m_slot.rs, m_slot.rd1));
                chk("rnd_alu_b", alu_b, m_slot.alusrc ? m_slot.imm : ref_fwd(m_slot.rt, m_slot.rd2));
                chk("rnd_store", ex_store_data, ref_fwd(m_slot.rt, m_slot.rd2));
                chk("rnd_dest", 32'(ex_dest), 32'(m_slot.regdst ? m_slot.rd : m_slot.rt));
                chk("rnd_imm", ex_imm, m_slot.imm);
            end
            // Next slot contents at the coming edge
            if (flush || exp_stall || !id_valid) begin
                m_valid = 1'b0;
                m_slot = blank();
            end else begin
                m_valid = 1'b1;
                m_slot = x;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
